// File: rtl/multicycle_ctrl_pkg.sv
// Shared RV32I controller definitions: state and class encodings, opcode constants,
// and write-back mux select codes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_e;

  // CLS_ALU is the reset value; LUI/AUIPC/OP/OP-IMM all write the ALU result.
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_JUMP   = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4
  } iclass_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  function automatic logic cls_writes_rf(input iclass_e c);
    return !(c == CLS_BRANCH || c == CLS_STORE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle controller (master) and the
// datapath / memories (slave).
interface multicycle_ctrl_if #(
  parameter int W_INSTRET = 32
);
  logic [6:0]           opcode;
  logic                 jump;
  logic                 imem_ack;
  logic                 dmem_ack;
  logic                 imem_req;
  logic                 ir_we;
  logic                 dmem_req;
  logic                 dmem_we;
  logic                 rf_we;
  logic [1:0]           wb_sel;
  logic                 pc_we;
  logic                 pc_sel;
  logic                 retire;
  logic [W_INSTRET-1:0] instret;
  logic                 trap;
  logic [2:0]           state;

  modport master (
    input  opcode, jump, imem_ack, dmem_ack,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
           pc_we, pc_sel, retire, instret, trap, state
  );

  modport slave (
    output opcode, jump, imem_ack, dmem_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
           pc_we, pc_sel, retire, instret, trap, state
  );
endinterface

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode classifier: maps the 7-bit major opcode to an instruction
// class and flags opcodes outside the supported RV32I base set.
module opcode_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output iclass_e    o_class,
  output logic       o_legal
);

  always_comb begin
    o_class = CLS_ALU;
    o_legal = 1'b1;
    case (i_opcode)
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM: o_class = CLS_ALU;
      OPC_JAL, OPC_JALR:                     o_class = CLS_JUMP;
      OPC_BRANCH:                            o_class = CLS_BRANCH;
      OPC_LOAD:                              o_class = CLS_LOAD;
      OPC_STORE:                             o_class = CLS_STORE;
      default:                               o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencing controller: FETCH/DECODE/EXECUTE/MEM/WB with a sticky
// illegal-opcode TRAP state and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int W_INSTRET = 32
) (
  input logic                clk,
  input logic                rst,
  multicycle_ctrl_if.master  bus
);

  state_e                r_state;
  state_e                w_next;
  iclass_e               r_class;
  iclass_e               w_dec_class;
  logic                  w_dec_legal;
  logic                  r_taken;
  logic                  r_trap;
  logic [W_INSTRET-1:0]  r_instret;

  logic       w_imem_req, w_ir_we, w_dmem_req, w_dmem_we;
  logic       w_rf_we, w_pc_we, w_pc_sel, w_retire;
  logic [1:0] w_wb_sel;

  opcode_class u_opcode_class (
    .i_opcode (bus.opcode),
    .o_class  (w_dec_class),
    .o_legal  (w_dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_class   <= CLS_ALU;
      r_taken   <= 1'b0;
      r_trap    <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_class <= w_dec_class;
        if (!w_dec_legal) r_trap <= 1'b1;
      end
      if (r_state == ST_EXECUTE) r_taken   <= bus.jump;
      if (r_state == ST_WB)      r_instret <= r_instret + 1'b1;
    end
  end

  // Outputs depend only on registered state/class, except ir_we which follows imem_ack.
  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_rf_we    = 1'b0;
    w_wb_sel   = WB_ALU;
    w_pc_we    = 1'b0;
    w_pc_sel   = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_ir_we = 1'b1;
          w_next  = ST_DECODE;
        end
      end
      ST_DECODE:  w_next = w_dec_legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: w_next = (r_class == CLS_LOAD || r_class == CLS_STORE) ? ST_MEM : ST_WB;
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_class == CLS_STORE);
        if (bus.dmem_ack) w_next = ST_WB;
      end
      ST_WB: begin
        w_pc_we  = 1'b1;
        w_pc_sel = r_taken;
        w_retire = 1'b1;
        w_rf_we  = cls_writes_rf(r_class);
        if (r_class == CLS_JUMP)      w_wb_sel = WB_PC4;
        else if (r_class == CLS_LOAD) w_wb_sel = WB_LOAD;
        w_next   = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_FETCH;
    endcase
  end

  // While rst is high every output reads as idle, so nothing leaks from the old state.
  assign bus.imem_req = w_imem_req & ~rst;
  assign bus.ir_we    = w_ir_we    & ~rst;
  assign bus.dmem_req = w_dmem_req & ~rst;
  assign bus.dmem_we  = w_dmem_we  & ~rst;
  assign bus.rf_we    = w_rf_we    & ~rst;
  assign bus.wb_sel   = rst ? 2'b00 : w_wb_sel;
  assign bus.pc_we    = w_pc_we    & ~rst;
  assign bus.pc_sel   = w_pc_sel   & ~rst;
  assign bus.retire   = w_retire   & ~rst;
  assign bus.trap     = r_trap     & ~rst;
  assign bus.instret  = rst ? '0 : r_instret;
  assign bus.state    = rst ? ST_FETCH : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks ALU, LOAD, BRANCH, JAL, STORE-with-reset,
// illegal opcode and counter wrap sequences with hand-computed expectations.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  multicycle_ctrl_if #(.W_INSTRET(32)) bif ();

  multicycle_ctrl #(.W_INSTRET(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] enables();
    return {bif.imem_req, bif.ir_we, bif.dmem_req, bif.dmem_we, bif.rf_we,
            bif.pc_we, bif.retire, bif.pc_sel, bif.wb_sel};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bif.opcode   = 7'b0;
    bif.jump     = 1'b0;
    bif.imem_ack = 1'b0;
    bif.dmem_ack = 1'b0;
    tick();
    chk("rst_state",    bif.state,    0);
    chk("rst_enables",  enables(),    0);
    chk("rst_trap",     bif.trap,     0);
    chk("rst_instret",  bif.instret,  0);

    // ADD with imem_ack tied high: 0,1,2,4,0
    rst = 1'b0; bif.opcode = 7'b0110011; bif.imem_ack = 1'b1;
    #1;
    chk("add_f_state",  bif.state,    0);
    chk("add_f_ireq",   bif.imem_req, 1);
    chk("add_f_irwe",   bif.ir_we,    1);
    tick();
    chk("add_d_state",  bif.state,    1);
    chk("add_d_en",     enables(),    0);
    tick();
    chk("add_e_state",  bif.state,    2);
    chk("add_e_en",     enables(),    0);
    tick();
    chk("add_wb_state", bif.state,    4);
    chk("add_wb_en",    enables(),    10'b00_0_0_1_1_1_0_00);
    chk("add_wb_cnt",   bif.instret,  0);
    tick();
    chk("add_f2_state", bif.state,    0);
    chk("add_f2_cnt",   bif.instret,  1);

    // LOAD with dmem_ack arriving on the 4th MEM cycle
    bif.opcode = 7'b0000011;
    tick();
    chk("ld_d_state",   bif.state,    1);
    tick();
    chk("ld_e_state",   bif.state,    2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_mem_state", bif.state,  3);
      chk("ld_mem_en",    enables(),  10'b00_1_0_0_0_0_0_00);
    end
    tick();
    bif.dmem_ack = 1'b1;
    #1;
    chk("ld_mem4_state", bif.state,   3);
    chk("ld_mem4_en",    enables(),   10'b00_1_0_0_0_0_0_00);
    tick();
    bif.dmem_ack = 1'b0;
    chk("ld_wb_state",  bif.state,    4);
    chk("ld_wb_en",     enables(),    10'b00_0_0_1_1_1_0_01);
    tick();
    chk("ld_cnt",       bif.instret,  2);

    // BEQ taken then not taken
    bif.opcode = 7'b1100011;
    tick(); tick();
    bif.jump = 1'b1;
    chk("beq1_e_state", bif.state,    2);
    tick();
    bif.jump = 1'b0;
    chk("beq1_wb_en",   enables(),    10'b00_0_0_0_1_1_1_00);
    tick();
    chk("beq1_cnt",     bif.instret,  3);
    tick(); tick();
    tick();
    chk("beq0_wb_en",   enables(),    10'b00_0_0_0_1_1_0_00);
    tick();
    chk("beq0_cnt",     bif.instret,  4);

    // JAL writes pc+4 and takes the jump target
    bif.opcode = 7'b1101111;
    tick(); tick();
    bif.jump = 1'b1;
    tick();
    bif.jump = 1'b0;
    chk("jal_wb_en",    enables(),    10'b00_0_0_1_1_1_1_10);
    tick();
    chk("jal_cnt",      bif.instret,  5);

    // STORE interrupted by reset in the 2nd MEM wait cycle
    bif.opcode = 7'b0100011;
    tick(); tick(); tick();
    chk("st_mem1_state", bif.state,   3);
    chk("st_mem1_en",    enables(),   10'b00_1_1_0_0_0_0_00);
    tick();
    rst = 1'b1;
    #1;
    chk("st_rst_dreq",  bif.dmem_req, 0);
    tick();
    chk("st_rst_state", bif.state,    0);
    chk("st_rst_en",    enables(),    0);
    chk("st_rst_cnt",   bif.instret,  0);
    rst = 1'b0; bif.opcode = 7'b0000000;
    #1;
    chk("st_post_ireq", bif.imem_req, 1);
    chk("st_post_irwe", bif.ir_we,    1);
    tick();
    chk("ill_d_state",  bif.state,    1);
    chk("ill_d_en",     enables(),    0);

    // Illegal opcode locks into TRAP until reset
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("trap_state", bif.state,    5);
      chk("trap_flag",  bif.trap,     1);
      chk("trap_en",    enables(),    0);
    end
    chk("trap_cnt",     bif.instret,  0);
    rst = 1'b1;
    tick();
    rst = 1'b0; bif.opcode = 7'b0110011;
    #1;
    chk("trap_rst_state", bif.state,  0);
    chk("trap_rst_flag",  bif.trap,   0);
    chk("trap_rst_ireq",  bif.imem_req, 1);

    // Counter wrap from all-ones
    tick(); tick(); tick();
    chk("wrap_wb_state", bif.state,   4);
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    tick();
    chk("wrap_cnt",     bif.instret,  0);
    chk("wrap_state",   bif.state,    0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter W_INSTRET, default 32, width of retired-instruction counter.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 opcode  in  7  instruction opcode field from instruction register; valid from DECODE onward.
REQ-005 jump  in  1  taken/jump indication from ex_stage; valid during EXECUTE.
REQ-006 imem_ack  in  1  instruction memory data valid.
REQ-007 dmem_ack  in  1  data memory access complete.
REQ-008 imem_req  out  1  instruction fetch request.
REQ-009 ir_we  out  1  instruction register write enable.
REQ-010 dmem_req  out  1  data memory request; dmem_we  out  1  store when high.
REQ-011 rf_we  out  1  register file write enable; wb_sel  out  2  00 ALU c, 01 load data, 10 pc+4.
REQ-012 pc_we  out  1  PC update enable; pc_sel  out  1  0 pc+4, 1 ex_stage c.
REQ-013 retire  out  1  one-cycle pulse per completed instruction; instret  out  W_INSTRET  retired count.
REQ-014 trap  out  1  illegal-opcode sticky flag; state  out  3  current state encoding for debug.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH.
REQ-016 FETCH: imem_req=1; on imem_ack sampled high: ir_we=1 that cycle, next DECODE; else stay.
REQ-017 imem_ack and dmem_ack SHALL be ignored outside FETCH and MEM, respectively.
REQ-018 DECODE: classify opcode; LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011; class registered at end of DECODE.
REQ-019 DECODE with any other opcode: next TRAP, no retire, no pc_we.
REQ-020 EXECUTE: one cycle; jump registered into taken_q at end of cycle; next MEM for LOAD/STORE, else WB.
REQ-021 MEM: dmem_req=1, dmem_we=1 for STORE only; on dmem_ack next WB, else stay.
REQ-022 WB: pc_we=1, pc_sel=taken_q, retire=1; next FETCH.
REQ-023 WB rf_we=1 for all classes except BRANCH and STORE.
REQ-024 wb_sel: 10 for JAL/JALR, 01 for LOAD, 00 otherwise; don't-care when rf_we=0 but SHALL be 00.
REQ-025 All enables/requests SHALL be 0 in any state not listed as asserting them.
REQ-026 Latency with single-cycle acks: non-memory instruction 4 cycles, LOAD/STORE 5 cycles, FETCH-to-FETCH.
REQ-027 instret SHALL increment by 1 on each WB cycle, wrapping from all-ones to 0.
REQ-028 TRAP: all enables 0, trap=1, remain until reset.
REQ-029 Outputs imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, retire, wb_sel, pc_sel SHALL be decoded from registered state/class only (no combinational path from acks except ir_we from imem_ack).

Reset
REQ-030 rst high at a rising edge SHALL force state=FETCH, taken_q=0, class=0, instret=0, trap=0, regardless of current state, including mid-MEM or mid-FETCH wait.
REQ-031 During the reset cycle all outputs SHALL be 0 except state=0; imem_req SHALL assert the first cycle after rst deasserts.
REQ-032 A request abandoned by reset SHALL not be retried; an ack arriving on the first cycle after reset in FETCH SHALL be accepted.

Structure
REQ-033 State encodings, opcode constants and wb_sel encodings SHALL live in the shared rv32i definitions include used by ex_stage.
REQ-034 Opcode classification SHALL be a combinational sub-module opcode_class (opcode in, class and legal out).
REQ-035 Controller core: one state register, one class register, taken_q, trap, instret; target 150-300 lines.

Verification
REQ-036 ADD (0110011), imem_ack tied 1 -> states 0,1,2,4,0; rf_we=1 wb_sel=00 pc_sel=0 at WB; instret 0->1.
REQ-037 LOAD with dmem_ack delayed 3 cycles -> MEM held 4 cycles, dmem_req=1 dmem_we=0 throughout, WB rf_we=1 wb_sel=01.
REQ-038 BEQ with jump=1 in EXECUTE -> WB pc_we=1 pc_sel=1 rf_we=0; with jump=0 -> pc_sel=0.
REQ-039 Opcode 0000000 -> TRAP, trap=1, all enables 0 for 20 cycles; rst -> FETCH, trap=0.
REQ-040 STORE, rst asserted in 2nd MEM wait cycle -> next cycle state=0, dmem_req=0, instret=0; following cycle imem_req=1.
REQ-041 Preload instret to all-ones (force), one retire -> instret=0.
